uart_rx_param: RTL

//  Parametrised UART receiver; successor to the fixed 8N1 uart_rx. Configurable data width, stop bits,

---
 rtl/uart_rx_param.sv | 265 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART receiver (data width, stop bits, oversampling).
// Front end: 2-flop synchroniser, start-bit glitch rejection and a 3-sample
// majority vote around mid-bit. Reports framing errors with each completed frame.
// Optional feature macro: UART_RX_PARITY_EN inserts a parity bit after the data bits.
// When the macro is undefined there is no parity logic and parity_err is tied to 0.
module uart_rx_param #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 8,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 d_in,
    input  logic                 rx_en,
    output logic [DATA_BITS-1:0] d_out,
    output logic                 done,
    output logic                 busy,
    output logic                 frame_err,
    output logic                 parity_err
);
    localparam int DIV    = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int TICK_W = $clog2(OVERSAMPLE);
    localparam int BIT_W  = $clog2(DATA_BITS);

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(DIV - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [TICK_W-1:0] TICK_V0   = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] TICK_V1   = TICK_W'(OVERSAMPLE / 2);
    localparam logic [TICK_W-1:0] TICK_V2   = TICK_W'(OVERSAMPLE / 2 + 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);
    localparam logic              STOP_LAST = 1'(STOP_BITS - 1);

    // Elaboration-time guard against parameter sets the receiver cannot handle.
    if ((OVERSAMPLE < 4) || (OVERSAMPLE % 2 != 0) || (DATA_BITS < 5) || (DATA_BITS > 9) ||
        ((STOP_BITS != 1) && (STOP_BITS != 2)) || (PARITY_ODD < 0) || (PARITY_ODD > 1) ||
        (DIV < 1)) begin : g_bad_cfg
        $error("uart_rx_param: illegal parameter combination");
    end

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } state_t;

    // Majority of three line samples.
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

`ifdef UART_RX_PARITY_EN
    // Even parity (XOR reduction) of the received word.
    function automatic logic calc_parity(input logic [DATA_BITS-1:0] w);
        return ^w;
    endfunction
`endif

    state_t               state_r, state_nxt_s;
    logic                 sync1_r, sync2_r, prev_r;
    logic                 armed_r;
    logic [DIV_W-1:0]     div_cnt_r;
    logic [TICK_W-1:0]    tick_cnt_r;
    logic [1:0]           vote_r;
    logic [BIT_W-1:0]     bit_idx_r;
    logic                 stop_idx_r;
    logic [DATA_BITS-1:0] shreg_r;
    logic                 ferr_acc_r;
    logic [DATA_BITS-1:0] d_out_r;
    logic                 done_r, busy_r, frame_err_r;
    logic                 busy_nxt_s, done_nxt_s;
`ifdef UART_RX_PARITY_EN
    logic                 par_bit_r, parity_err_r;
`endif

    // Decoded timing and control events; the vote point is the third sample of a bit.
    logic start_s, sample_s, vote_pt_s, bit_end_s, voted_s, frame_end_s, ferr_now_s;
    assign start_s     = rx_en & armed_r & prev_r & ~sync2_r;
    assign sample_s    = (div_cnt_r == {DIV_W{1'b0}});
    assign vote_pt_s   = sample_s & (tick_cnt_r == TICK_V2);
    assign bit_end_s   = (div_cnt_r == DIV_LAST) & (tick_cnt_r == TICK_LAST);
    assign voted_s     = maj3(vote_r[1], vote_r[0], sync2_r);
    assign frame_end_s = (state_r == ST_STOP) & rx_en & vote_pt_s & (stop_idx_r == STOP_LAST);
    assign ferr_now_s  = ferr_acc_r | ~voted_s;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; dropping rx_en aborts any frame in progress.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_s) state_nxt_s = ST_START;
                else         state_nxt_s = ST_IDLE;
            end
            ST_START: begin
                if (!rx_en)                     state_nxt_s = ST_IDLE;
                else if (vote_pt_s && voted_s)  state_nxt_s = ST_IDLE;
                else if (bit_end_s)             state_nxt_s = ST_DATA;
                else                            state_nxt_s = ST_START;
            end
            ST_DATA: begin
                if (!rx_en)                                   state_nxt_s = ST_IDLE;
`ifdef UART_RX_PARITY_EN
                else if (bit_end_s && (bit_idx_r == BIT_LAST)) state_nxt_s = ST_PARITY;
`else
                else if (bit_end_s && (bit_idx_r == BIT_LAST)) state_nxt_s = ST_STOP;
`endif
                else                                          state_nxt_s = ST_DATA;
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (!rx_en)         state_nxt_s = ST_IDLE;
                else if (bit_end_s) state_nxt_s = ST_STOP;
                else                state_nxt_s = ST_PARITY;
            end
`endif
            ST_STOP: begin
                if (!rx_en)           state_nxt_s = ST_IDLE;
                else if (frame_end_s) state_nxt_s = ST_IDLE;
                else                  state_nxt_s = ST_STOP;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Output decode, registered below so busy tracks the state register exactly.
    always_comb begin
        busy_nxt_s = 1'b0;
        done_nxt_s = 1'b0;
        if (state_nxt_s != ST_IDLE) busy_nxt_s = 1'b1;
        else                        busy_nxt_s = 1'b0;
        if (frame_end_s) done_nxt_s = 1'b1;
        else             done_nxt_s = 1'b0;
    end

    // Input synchroniser, edge-detect history and break re-arm flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
            prev_r  <= 1'b1;
            armed_r <= 1'b1;
        end else begin
            sync1_r <= d_in;
            sync2_r <= sync1_r;
            prev_r  <= sync2_r;
            if (frame_end_s && ferr_now_s)          armed_r <= 1'b0;
            else if ((state_r == ST_IDLE) && sync2_r) armed_r <= 1'b1;
            else                                      armed_r <= armed_r;
        end
    end

    // Baud divider and oversample tick counter; both restart whenever the FSM is idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt_r  <= {DIV_W{1'b0}};
            tick_cnt_r <= {TICK_W{1'b0}};
        end else if (state_r == ST_IDLE) begin
            div_cnt_r  <= {DIV_W{1'b0}};
            tick_cnt_r <= {TICK_W{1'b0}};
        end else if (div_cnt_r == DIV_LAST) begin
            div_cnt_r <= {DIV_W{1'b0}};
            if (tick_cnt_r == TICK_LAST) tick_cnt_r <= {TICK_W{1'b0}};
            else                         tick_cnt_r <= tick_cnt_r + TICK_W'(1'b1);
        end else begin
            div_cnt_r  <= div_cnt_r + DIV_W'(1'b1);
            tick_cnt_r <= tick_cnt_r;
        end
    end

    // Frame datapath: vote samples, shift data, count bits and accumulate stop errors.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vote_r     <= 2'b11;
            bit_idx_r  <= {BIT_W{1'b0}};
            stop_idx_r <= 1'b0;
            shreg_r    <= {DATA_BITS{1'b0}};
            ferr_acc_r <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit_r  <= 1'b0;
`endif
        end else if (state_r == ST_IDLE) begin
            bit_idx_r  <= {BIT_W{1'b0}};
            stop_idx_r <= 1'b0;
            ferr_acc_r <= 1'b0;
        end else begin
            if (sample_s && (tick_cnt_r == TICK_V0))      vote_r[1] <= sync2_r;
            else if (sample_s && (tick_cnt_r == TICK_V1)) vote_r[0] <= sync2_r;
            else                                          vote_r    <= vote_r;
            case (state_r)
                ST_DATA: begin
                    if (vote_pt_s) shreg_r <= {voted_s, shreg_r[DATA_BITS-1:1]};
                    else           shreg_r <= shreg_r;
                    if (bit_end_s) bit_idx_r <= bit_idx_r + BIT_W'(1'b1);
                    else           bit_idx_r <= bit_idx_r;
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (vote_pt_s) par_bit_r <= voted_s;
                    else           par_bit_r <= par_bit_r;
                end
`endif
                ST_STOP: begin
                    if (vote_pt_s && !voted_s) ferr_acc_r <= 1'b1;
                    else                       ferr_acc_r <= ferr_acc_r;
                    if (bit_end_s) stop_idx_r <= ~stop_idx_r;
                    else           stop_idx_r <= stop_idx_r;
                end
                default: shreg_r <= shreg_r;
            endcase
        end
    end

    // Registered outputs; word and error flags change only when a frame completes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            d_out_r      <= {DATA_BITS{1'b0}};
            done_r       <= 1'b0;
            busy_r       <= 1'b0;
            frame_err_r  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_r <= 1'b0;
`endif
        end else begin
            done_r <= done_nxt_s;
            busy_r <= busy_nxt_s;
            if (frame_end_s) begin
                d_out_r      <= shreg_r;
                frame_err_r  <= ferr_now_s;
`ifdef UART_RX_PARITY_EN
                parity_err_r <= (calc_parity(shreg_r) ^ PARITY_ODD[0]) ^ par_bit_r;
`endif
            end else begin
                d_out_r     <= d_out_r;
                frame_err_r <= frame_err_r;
            end
        end
    end

    assign d_out     = d_out_r;
    assign done      = done_r;
    assign busy      = busy_r;
    assign frame_err = frame_err_r;
`ifdef UART_RX_PARITY_EN
    assign parity_err = parity_err_r;
`else
    assign parity_err = 1'b0;
`endif

endmodule
